// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 4-bit processor sequencer.
//   - opcode classes taken from IR[7:6]
//   - ALU operation codes driven on alu_op
//   - write-data mux selections driven on wdata_sel
//   - sequencer state enumeration
package cpu_pkg;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_STORE = 2'd1;
  localparam logic [1:0] OP_MOVE  = 2'd2;
  localparam logic [1:0] OP_ALU   = 2'd3;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_SUB  = 2'd1;
  localparam logic [1:0] ALU_AND  = 2'd2;
  localparam logic [1:0] ALU_NOT  = 2'd3;

  localparam logic [1:0] WSEL_IMM  = 2'd0;
  localparam logic [1:0] WSEL_REGB = 2'd1;
  localparam logic [1:0] WSEL_ALU  = 2'd2;

  // STALL is only reachable when single-step support is compiled in.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    HALT    = 3'd4,
    STALL   = 3'd5
  } state_t;

endpackage

// File: rtl/cpu_sequencer_instr_decode.sv
// instr_decode: purely combinational instruction decoder.
// Ports:
//   ir          in  8  latched instruction
//   rf_raddr_a  out 2  read port A (IR[5:4])
//   rf_raddr_b  out 2  read port B (IR[3:2])
//   rf_waddr    out 2  write address (IR[5:4])
//   rf_we_req   out 1  instruction writes the register file
//   led_we_req  out 1  instruction writes the LED register
//   wdata_sel   out 2  write-data mux selection
//   imm         out 4  immediate (LOAD only, 0 otherwise)
//   alu_op      out 2  ALU operation (ALU class only, add otherwise)
module instr_decode
  import cpu_pkg::*;
(
  input  logic [7:0] ir,
  output logic [1:0] rf_raddr_a,
  output logic [1:0] rf_raddr_b,
  output logic [1:0] rf_waddr,
  output logic       rf_we_req,
  output logic       led_we_req,
  output logic [1:0] wdata_sel,
  output logic [3:0] imm,
  output logic [1:0] alu_op
);

  // Field extraction and per-class request generation.
  always_comb begin
    rf_raddr_a = ir[5:4];
    rf_raddr_b = ir[3:2];
    rf_waddr   = ir[5:4];
    rf_we_req  = 1'b0;
    led_we_req = 1'b0;
    wdata_sel  = WSEL_IMM;
    imm        = 4'd0;
    alu_op     = ALU_ADD;
    case (ir[7:6])
      OP_LOAD: begin
        rf_we_req = 1'b1;
        wdata_sel = WSEL_IMM;
        imm       = ir[3:0];
      end
      OP_STORE: begin
        led_we_req = 1'b1;
      end
      OP_MOVE: begin
        rf_we_req = 1'b1;
        wdata_sel = WSEL_REGB;
      end
      OP_ALU: begin
        rf_we_req = 1'b1;
        wdata_sel = WSEL_ALU;
        alu_op    = ir[1:0];
      end
      default: begin
        rf_we_req  = 1'b0;
        led_we_req = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute controller for the 4-bit processor.
// Each instruction takes FETCH, DECODE and EXECUTE (three clocks); the
// sequencer halts after executing the instruction at END_ADDR.
// Optional feature macro: SINGLE_STEP_EN (adds the step input; FETCH is
// only entered on a cycle with step=1, otherwise the FSM waits in STALL).
// Parameters:
//   START_ADDR  PC loaded on reset and on restart from HALT
//   END_ADDR    address of the last instruction
// Ports:
//   clk, reset        clock (rising edge), async active-high reset
//   run               start request / HALT release (when 0)
//   step              single-step enable (SINGLE_STEP_EN only)
//   instruction       combinational ROM data for ProgramCounter
//   ProgramCounter    ROM address
//   rf_raddr_a/b      register-file read addresses
//   rf_waddr, rf_we   register-file write address and one-cycle strobe
//   wdata_sel         write-data mux: 0 imm, 1 port B, 2 ALU
//   imm, alu_op       immediate and ALU operation
//   led_we            one-cycle LED store strobe (captures port A)
//   busy, halted      status: FETCH/DECODE/EXECUTE, HALT
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [3:0] START_ADDR = 4'd1,
  parameter logic [3:0] END_ADDR   = 4'd8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
`ifdef SINGLE_STEP_EN
  input  logic       step,
`endif
  input  logic [7:0] instruction,
  output logic [3:0] ProgramCounter,
  output logic [1:0] rf_raddr_a,
  output logic [1:0] rf_raddr_b,
  output logic [1:0] rf_waddr,
  output logic       rf_we,
  output logic [1:0] wdata_sel,
  output logic [3:0] imm,
  output logic [1:0] alu_op,
  output logic       led_we,
  output logic       busy,
  output logic       halted
);

  state_t     state;
  state_t     launch_state;
  logic [7:0] ir;
  logic       rf_we_req;
  logic       led_we_req;

  // Where the FSM goes when it would otherwise start a new fetch.
`ifdef SINGLE_STEP_EN
  assign launch_state = step ? FETCH : STALL;
`else
  assign launch_state = FETCH;
`endif

  // Main sequencer FSM, program counter and instruction register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      ProgramCounter <= START_ADDR;
      ir             <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (run) state <= launch_state;
          else     state <= IDLE;
        end
        FETCH: begin
          state <= DECODE;
        end
        DECODE: begin
          ir    <= instruction;
          state <= EXECUTE;
        end
        EXECUTE: begin
          if (ProgramCounter == END_ADDR) begin
            state <= HALT;
          end else begin
            // 4-bit add wraps 15 -> 0 naturally.
            ProgramCounter <= ProgramCounter + 4'd1;
            state          <= launch_state;
          end
        end
        HALT: begin
          if (!run) begin
            state          <= IDLE;
            ProgramCounter <= START_ADDR;
          end else begin
            state <= HALT;
          end
        end
        STALL: begin
          state <= launch_state;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Decoded fields come straight from the held IR, so they keep their last
  // decode outside EXECUTE; only the strobes are qualified by state.
  instr_decode u_decode (
    .ir         (ir),
    .rf_raddr_a (rf_raddr_a),
    .rf_raddr_b (rf_raddr_b),
    .rf_waddr   (rf_waddr),
    .rf_we_req  (rf_we_req),
    .led_we_req (led_we_req),
    .wdata_sel  (wdata_sel),
    .imm        (imm),
    .alu_op     (alu_op)
  );

  // Strobes and status are functions of registered state only; async reset
  // forces IDLE, which drops any strobe in the same cycle.
  assign rf_we  = (state == EXECUTE) && rf_we_req;
  assign led_we = (state == EXECUTE) && led_we_req;
  assign busy   = (state == FETCH) || (state == DECODE) || (state == EXECUTE);
  assign halted = (state == HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed self-checking bench for cpu_sequencer.
// u0 runs the default program (START 1, END 8) against a small model of the
// register file, ALU and LED register; u1 (START 14, END 1) exercises
// PC wrap-around. Define SINGLE_STEP_EN to also exercise single-step mode.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       run1;
  logic       step;
  logic       step1;

  logic [7:0] instr0, instr1;
  logic [3:0] pc0, pc1;
  logic [1:0] ra0, rb0, wa0, ws0, op0;
  logic [1:0] ra1, rb1, wa1, ws1, op1;
  logic [3:0] imm0, imm1;
  logic       rfwe0, ledwe0, busy0, halted0;
  logic       rfwe1, ledwe1, busy1, halted1;

  logic [7:0] rom0 [16];
  logic [7:0] rom1 [16];
  logic [3:0] regs [4];
  logic [3:0] leds;
  int         strobes0 = 0;
  int         strobes1 = 0;
  int         leds_writes = 0;

  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  assign instr0 = rom0[pc0];
  assign instr1 = rom1[pc1];

  cpu_sequencer #(.START_ADDR(4'd1), .END_ADDR(4'd8)) u0 (
    .clk(clk), .reset(reset), .run(run),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .instruction(instr0), .ProgramCounter(pc0),
    .rf_raddr_a(ra0), .rf_raddr_b(rb0), .rf_waddr(wa0), .rf_we(rfwe0),
    .wdata_sel(ws0), .imm(imm0), .alu_op(op0), .led_we(ledwe0),
    .busy(busy0), .halted(halted0)
  );

  cpu_sequencer #(.START_ADDR(4'd14), .END_ADDR(4'd1)) u1 (
    .clk(clk), .reset(reset), .run(run1),
`ifdef SINGLE_STEP_EN
    .step(step1),
`endif
    .instruction(instr1), .ProgramCounter(pc1),
    .rf_raddr_a(ra1), .rf_raddr_b(rb1), .rf_waddr(wa1), .rf_we(rfwe1),
    .wdata_sel(ws1), .imm(imm1), .alu_op(op1), .led_we(ledwe1),
    .busy(busy1), .halted(halted1)
  );

  function automatic logic [3:0] alu_f(input logic [1:0] op, input logic [3:0] a,
                                       input logic [3:0] b);
    case (op)
      2'd0:    alu_f = a + b;
      2'd1:    alu_f = a - b;
      2'd2:    alu_f = a & b;
      default: alu_f = ~a;
    endcase
  endfunction

  // Datapath model around u0, plus strobe counters for both DUTs.
  always @(posedge clk) begin
    if (rfwe0) begin
      case (ws0)
        2'd0:    regs[wa0] <= imm0;
        2'd1:    regs[wa0] <= regs[rb0];
        default: regs[wa0] <= alu_f(op0, regs[ra0], regs[rb0]);
      endcase
    end
    if (ledwe0) begin
      leds        <= regs[ra0];
      leds_writes <= leds_writes + 1;
    end
    if (rfwe0 || ledwe0) strobes0 <= strobes0 + 1;
    if (rfwe1 || ledwe1) strobes1 <= strobes1 + 1;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_pc;
    int         s0;
    int         lw0;

    for (int i = 0; i < 16; i++) begin
      rom0[i] = 8'h00;
      rom1[i] = 8'h00;
    end
    rom0[1] = 8'h01;  // LOAD r0,1
    rom0[2] = 8'hA0;  // MOVE r2<-r0
    rom0[3] = 8'h98;  // MOVE r1<-r2
    rom0[4] = 8'hD8;  // ADD  r1+=r2
    rom0[5] = 8'hD2;  // AND  r1&=r0
    rom0[6] = 8'hC9;  // SUB  r0-=r2
    rom0[7] = 8'hC3;  // NOT  r0
    rom0[8] = 8'h40;  // STORE r0
    rom1[14] = 8'h02; // LOAD r0,2
    rom1[15] = 8'h13; // LOAD r1,3
    rom1[0]  = 8'hC4; // ADD r0+=r1
    rom1[1]  = 8'h40; // STORE r0

    reset = 1'b1; run = 1'b0; run1 = 1'b0; step = 1'b1; step1 = 1'b1;
    tick(3);
    // Reset state.
    check("rst_pc", pc0, 4'd1);
    check("rst_busy", busy0, 1'b0);
    check("rst_halted", halted0, 1'b0);
    check("rst_strobes", {rfwe0, ledwe0}, 2'b00);
    check("rst_fields", {ra0, rb0, wa0, ws0, imm0, op0}, 14'd0);
    check("rst_pc1", pc1, 4'd14);
    reset = 1'b0;
    tick(2);
    check("idle_no_run", busy0, 1'b0);

    // Default program: tick 1 is the edge that samples run=1.
    run = 1'b1;
    tick(1);
    check("first_fetch_busy", busy0, 1'b1);
    tick(2);
    check("load_exec", {rfwe0, ledwe0, wa0, ws0, imm0}, {1'b1, 1'b0, 2'd0, 2'd0, 4'd1});
    tick(9);
    check("add_exec", {ra0, rb0, wa0, op0, ws0, rfwe0, ledwe0},
          {2'd1, 2'd2, 2'd1, 2'd0, 2'd2, 1'b1, 1'b0});
    tick(1);
    check("add_one_cycle", rfwe0, 1'b0);
    check("pc_after_add", pc0, 4'd5);
    tick(3);
    check("regs_after_and", {regs[0], regs[1], regs[2]}, {4'd1, 4'd0, 4'd1});
    tick(3);
    check("r0_before_not", regs[0], 4'd0);
    tick(3);
    check("r0_after_not", regs[0], 4'd15);
    tick(2);
    check("store_exec", {ledwe0, rfwe0, ra0, halted0}, {1'b1, 1'b0, 2'd0, 1'b0});
    tick(1);
    check("halt_at_24", {halted0, busy0}, 2'b10);
    check("leds_final", leds, 4'd15);
    check("strobe_count", strobes0, 8);

    // HALT holds with run=1, then run=0 returns to IDLE with PC reloaded.
    tick(5);
    check("halt_hold", {halted0, pc0}, {1'b1, 4'd8});
    run = 1'b0;
    tick(1);
    check("halt_release", {halted0, busy0, pc0}, {1'b0, 1'b0, 4'd1});

    // Reset during DECODE of PC=5.
    run = 1'b1;
    tick(14);
    check("decode_pc5", {busy0, pc0, rfwe0, ledwe0}, {1'b1, 4'd5, 1'b0, 1'b0});
    s0 = strobes0;
    reset = 1'b1;
    #1;
    check("abort_now", {pc0, busy0, halted0, rfwe0, ledwe0}, {4'd1, 1'b0, 1'b0, 1'b0, 1'b0});
    tick(1);
    check("abort_no_strobe", strobes0, s0);
    lw0 = leds_writes;
    reset = 1'b0;
    tick(24);
    check("rerun_not_halted", halted0, 1'b0);
    tick(1);
    check("rerun_halted", halted0, 1'b1);
    check("rerun_leds", {leds, 4'(leds_writes - lw0)}, {4'd15, 4'd1});
    run = 1'b0;
    tick(1);

    // Wrap-around on u1: 14, 15, 0, 1.
    exp_pc = 4'd14;
    run1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(3);
      check("wrap_exec_pc", {pc1, 1'(rfwe1 | ledwe1)}, {exp_pc, 1'b1});
      exp_pc = exp_pc + 4'd1;
    end
    check("wrap_not_halted", halted1, 1'b0);
    tick(1);
    check("wrap_halted", {halted1, pc1, 4'(strobes1)}, {1'b1, 4'd1, 4'd4});
    run1 = 1'b0;
    tick(1);

`ifdef SINGLE_STEP_EN
    // Single-step: three step pulses with gaps give exactly three instructions.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    step = 1'b0;
    s0 = strobes0;
    run = 1'b1;
    tick(3);
    check("step_stall", {busy0, pc0}, {1'b0, 4'd1});
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      tick(1);
      step = 1'b0;
      check("step_busy", busy0, 1'b1);
      tick(3);
      check("step_gap", busy0, 1'b0);
      tick(2);
      check("step_gap_hold", busy0, 1'b0);
    end
    check("step_count", {pc0, 4'(strobes0 - s0)}, {4'd4, 4'd3});
    step = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
